// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute stage: opcode values, FSM encoding and
// register-file geometry, reused by decode and by benches.
package exec_unit_pkg;

  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_IDX_W = 2;
  localparam int unsigned OP_W      = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT  = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h9;
  localparam logic [OP_W-1:0] OP_INC  = 4'hA;
  localparam logic [OP_W-1:0] OP_DEC  = 4'hB;
  localparam logic [OP_W-1:0] OP_CMP  = 4'hC;
  localparam logic [OP_W-1:0] OP_MUL  = 4'hD;
  localparam logic [OP_W-1:0] OP_OUT  = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles.
// done_c/product_c are combinational and valid in the last iteration cycle.
module exec_mul_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done_c,
  output logic [2*DATA_W-1:0]   product_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  // Accumulator after the current step; equals the full product on the last step.
  always_comb begin
    product_c = mplier[0] ? acc + mcand : acc;
    done_c    = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= PROD_W'(a);
      mplier <= b;
      cnt    <= CNT_W'(DATA_W);
    end else if (cnt != '0) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: 4-entry register file, single-cycle ALU, iterative multiply,
// OUT port and sticky HALT.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      op_code,
  input  logic [REG_IDX_W-1:0] dst_reg,
  input  logic [REG_IDX_W-1:0] src_reg,
  output logic [DATA_W-1:0]    out_port,
  output logic                 out_strobe,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 busy,
  output logic                 halted,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data
);

  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  state_t                 state;
  logic [DATA_W-1:0]      rf [NUM_REGS];
  logic [REG_IDX_W-1:0]   mul_dst;

  logic                   accept;
  logic [DATA_W-1:0]      rd_d;
  logic [DATA_W-1:0]      rd_s;
  logic [SUM_W-1:0]       sum;
  logic [DATA_W-1:0]      alu_res;
  logic                   alu_c;
  logic                   alu_wr;
  logic                   alu_fl;

  logic                   mul_start;
  logic                   mul_done_c;
  logic [PROD_W-1:0]      mul_prod;

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign rd_d      = rf[dst_reg];
  assign rd_s      = rf[src_reg];
  assign dbg_data  = rf[dbg_sel];
  assign mul_start = accept && (op_code == OP_MUL);

  exec_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .a         (rd_d),
    .b         (rd_s),
    .done_c    (mul_done_c),
    .product_c (mul_prod)
  );

  // Single-cycle ALU; the carry slot holds carry, borrow or the shifted-out bit.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b0;
    alu_fl  = 1'b0;
    case (op_code)
      OP_MOV: begin
        alu_res = rd_s;
        alu_wr  = 1'b1;
      end
      OP_ADD: begin
        sum     = {1'b0, rd_d} + {1'b0, rd_s};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        sum     = {1'b0, rd_d} - {1'b0, rd_s};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_wr  = (op_code == OP_SUB);
        alu_fl  = 1'b1;
      end
      OP_AND: begin
        alu_res = rd_d & rd_s;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_OR: begin
        alu_res = rd_d | rd_s;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_XOR: begin
        alu_res = rd_d ^ rd_s;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_NOT: begin
        alu_res = ~rd_s;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_SHL: begin
        alu_res = rd_d << 1;
        alu_c   = rd_d[DATA_W-1];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_SHR: begin
        alu_res = rd_d >> 1;
        alu_c   = rd_d[0];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_INC: begin
        sum     = {1'b0, rd_d} + SUM_W'(1);
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      OP_DEC: begin
        sum     = {1'b0, rd_d} - SUM_W'(1);
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      default: ;
    endcase
  end

  // Control FSM with register file, flags and output port updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rf         <= '{default: '0};
      mul_dst    <= '0;
      out_port   <= '0;
      out_strobe <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (alu_wr) begin
              rf[dst_reg] <= alu_res;
            end
            if (alu_fl) begin
              flag_z <= (alu_res == '0);
              flag_c <= alu_c;
            end
            case (op_code)
              OP_MUL: begin
                state   <= ST_MUL;
                busy    <= 1'b1;
                mul_dst <= dst_reg;
              end
              OP_OUT: begin
                out_port   <= rd_d;
                out_strobe <= 1'b1;
              end
              OP_HALT: begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_done_c) begin
            rf[mul_dst] <= mul_prod[DATA_W-1:0];
            flag_z      <= (mul_prod[DATA_W-1:0] == '0);
            flag_c      <= |mul_prod[PROD_W-1:DATA_W];
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: the driver pushes the architectural state
// predicted by an integer model; a negedge monitor compares the DUT against it.
module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [4*W-1:0] regs;
    logic           z;
    logic           c;
    logic [W-1:0]   outp;
    logic           strobe;
    logic           halted;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op_code;
  logic [1:0]   dst_reg;
  logic [1:0]   src_reg;
  logic [W-1:0] out_port;
  logic         out_strobe;
  logic         flag_z;
  logic         flag_c;
  logic         busy;
  logic         halted;
  logic [1:0]   dbg_sel;
  logic [W-1:0] dbg_data;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  bit   in_rst;

  int   m_r[4];
  bit   m_z, m_c, m_halt;
  int   m_out;

  exec_unit #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_code    (op_code),
    .dst_reg    (dst_reg),
    .src_reg    (src_reg),
    .out_port   (out_port),
    .out_strobe (out_strobe),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .busy       (busy),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_z = 0; m_c = 0; m_halt = 0; m_out = 0;
  endtask

  function automatic exp_t snap(input bit st);
    exp_t e;
    for (int i = 0; i < 4; i++) e.regs[i*W +: W] = W'(m_r[i]);
    e.z      = m_z;
    e.c      = m_c;
    e.outp   = W'(m_out);
    e.strobe = st;
    e.halted = m_halt;
    return e;
  endfunction

  // Architectural effect of one instruction, in plain integer arithmetic mod 256.
  task automatic model_exec(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s);
    int a, b, res, r8;
    bit wr, fl, cf, st;
    a = m_r[d]; b = m_r[s];
    res = 0; wr = 1; fl = 1; cf = 0; st = 0;
    case (op)
      OP_NOP:  begin wr = 0; fl = 0; end
      OP_MOV:  begin res = b; fl = 0; end
      OP_ADD:  begin res = a + b; cf = (res > 255); end
      OP_SUB:  begin res = a - b; cf = (a < b); end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = 255 - b;
      OP_SHL:  begin res = a * 2; cf = (a >= 128); end
      OP_SHR:  begin res = a / 2; cf = (a % 2 == 1); end
      OP_INC:  begin res = a + 1; cf = (a == 255); end
      OP_DEC:  begin res = a - 1; cf = (a == 0); end
      OP_CMP:  begin res = a - b; cf = (a < b); wr = 0; end
      OP_MUL:  begin res = a * b; cf = (res >= 256); end
      OP_OUT:  begin m_out = a; st = 1; wr = 0; fl = 0; end
      default: begin m_halt = 1; wr = 0; fl = 0; end
    endcase
    r8 = ((res % 256) + 256) % 256;
    if (wr) m_r[d] = r8;
    if (fl) begin m_z = (r8 == 0); m_c = cf; end
    sb.push_back(snap(st));
  endtask

  // Present an instruction and hold it until the unit accepts it (bounded).
  task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s);
    bit done;
    done = 0;
    in_valid = 1'b1; op_code = op; dst_reg = d; src_reg = s;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_exec(op, d, s);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit with_valid);
    rst = 1'b1; in_rst = 1'b1;
    in_valid = with_valid; op_code = OP_INC; dst_reg = 2'd0; src_reg = 2'd0;
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_rst = 1'b0; in_valid = 1'b0;
  endtask

  // Monitor: retire expected states and compare the full visible state every cycle.
  initial begin : monitor
    exp_t          cur;
    int            mul_left;
    bit            ret, acc, st_exp;
    logic [3:0]    aop;
    logic          s_rdy, s_busy, s_halt, s_z, s_c, s_stb;
    logic [W-1:0]  s_out;
    logic [4*W-1:0] rg;
    cur = '0; mul_left = 0; ret = 0; dbg_sel = 2'd0; rg = '0;
    forever begin
      @(negedge clk);
      s_rdy = in_ready; s_busy = busy; s_halt = halted;
      s_z = flag_z; s_c = flag_c; s_stb = out_strobe; s_out = out_port;
      acc = in_valid && s_rdy; aop = op_code;
      if (in_rst) begin
        check("ready_in_rst", 32'(s_rdy), 32'd0);
        cur = '0; mul_left = 0; ret = 0;
      end else begin
        st_exp = 0;
        if (ret) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            st_exp = cur.strobe;
          end
          ret = 0;
        end
        for (int i = 0; i < 4; i++) begin
          dbg_sel = 2'(i);
          #1;
          rg[i*W +: W] = dbg_data;
        end
        check("regs",       32'(rg),     32'(cur.regs));
        check("flag_z",     32'(s_z),    32'(cur.z));
        check("flag_c",     32'(s_c),    32'(cur.c));
        check("out_port",   32'(s_out),  32'(cur.outp));
        check("out_strobe", 32'(s_stb),  32'(st_exp));
        check("halted",     32'(s_halt), 32'(cur.halted));
        check("busy",       32'(s_busy), 32'(mul_left > 0));
        check("in_ready",   32'(s_rdy),  32'(!cur.halted && mul_left == 0));
        if (mul_left > 0) begin
          mul_left--;
          if (mul_left == 0) ret = 1;
        end
        if (acc) begin
          if (aop == OP_MUL) mul_left = int'(W);
          else ret = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1; in_rst = 1'b1; in_valid = 1'b0;
    op_code = OP_NOP; dst_reg = 2'd0; src_reg = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_rst = 1'b0;

    repeat (5) issue(OP_INC, 2'd0, 2'd0);
    repeat (3) issue(OP_INC, 2'd1, 2'd1);
    issue(OP_MUL, 2'd0, 2'd1);
    issue(OP_INC, 2'd3, 2'd3);
    issue(OP_DEC, 2'd2, 2'd2);
    issue(OP_INC, 2'd2, 2'd2);
    issue(OP_NOT, 2'd2, 2'd2);
    issue(OP_OUT, 2'd0, 2'd0);
    issue(OP_CMP, 2'd0, 2'd0);
    issue(OP_SUB, 2'd1, 2'd1);
    issue(OP_MUL, 2'd2, 2'd2);
    idle(2);

    issue(OP_MUL, 2'd0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    do_reset(1'b1);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      idle(int'($urandom_range(0, 2)));
      issue(4'($urandom_range(0, 14)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    idle(12);

    issue(OP_HALT, 2'd0, 2'd0);
    for (int n = 0; n < 20; n++) begin
      in_valid = 1'b1;
      op_code  = 4'($urandom_range(0, 14));
      dst_reg  = 2'($urandom_range(0, 3));
      src_reg  = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_reset(1'b0);
    issue(OP_INC, 2'd1, 2'd1);
    issue(OP_OUT, 2'd1, 2'd1);
    idle(12);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
